// File: rtl/prng_mux_engine.sv
// prng_mux_engine: two XNOR LFSRs on tick/step enables scrambled into a valid/ready byte stream (clk, reset, ena, mode, step, seed_load/seed_data/seed_ctrl in; out_valid/out_data, lockup, overrun out; out_ready in)
module prng_mux_engine #(
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] DATA_TAPS = 16'hD008,
  parameter logic [DATA_W/2-1:0] CTRL_TAPS = 8'hB8,
  parameter logic [23:0] DIV_DATA = 24'd10_000_000,
  parameter logic [23:0] DIV_CTRL = 24'd2_500_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic                mode,
  input  logic                step,
  input  logic                seed_load,
  input  logic [DATA_W-1:0]   seed_data,
  input  logic [DATA_W/2-1:0] seed_ctrl,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W/2-1:0] out_data,
  output logic                lockup,
  output logic                overrun
);
  localparam int CW = DATA_W / 2;
  logic [DATA_W-1:0] data_q, data_d, data_sh;
  logic [CW-1:0] ctrl_q, ctrl_d, ctrl_sh, out_data_q, scr;
  logic [23:0] cd_q, cc_q;
  logic valid_q, lock_q, ovr_q;
  logic run, st, tick_d, tick_c, adv_d, adv_c, lock_hit;
  always_comb begin
    run = ena & ~mode;
    st = ena & mode & step;
    tick_d = run && cd_q == DIV_DATA - 24'd1;
    tick_c = run && cc_q == DIV_CTRL - 24'd1;
    adv_d = ~seed_load & (tick_d | st);
    adv_c = ~seed_load & (tick_c | st);
    data_sh = {data_q[DATA_W-2:0], ~^(data_q & DATA_TAPS)};
    ctrl_sh = {ctrl_q[CW-2:0], ~^(ctrl_q & CTRL_TAPS)};
    data_d = seed_load ? seed_data : adv_d ? (&data_sh ? '0 : data_sh) : data_q;
    ctrl_d = seed_load ? seed_ctrl : adv_c ? (&ctrl_sh ? '0 : ctrl_sh) : ctrl_q;
    lock_hit = (adv_d & (&data_sh)) | (adv_c & (&ctrl_sh));
    scr = '0;
    for (int i = 0; i < CW; i++) scr[i] = ctrl_d[i] ? data_d[2*i+1] : data_d[2*i];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      ctrl_q <= '0;
      cd_q <= '0;
      cc_q <= '0;
      valid_q <= 1'b0;
      out_data_q <= '0;
      lock_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
      cd_q <= seed_load ? '0 : run ? (tick_d ? '0 : cd_q + 24'd1) : cd_q;
      cc_q <= seed_load ? '0 : run ? (tick_c ? '0 : cc_q + 24'd1) : cc_q;
      lock_q <= seed_load ? 1'b0 : lock_q | lock_hit;
      if (adv_d) begin
        if (!valid_q || out_ready) begin
          out_data_q <= scr;
          valid_q <= 1'b1;
        end else ovr_q <= 1'b1;
      end else if (valid_q && out_ready) valid_q <= 1'b0;
    end
  end
  assign out_valid = valid_q;
  assign out_data = out_data_q;
  assign lockup = lock_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_prng_mux_engine.sv
// tb_prng_mux_engine: randomized and directed checks of prng_mux_engine against a behavioural model
module tb_prng_mux_engine;
  localparam int DD = 4;
  localparam int DC = 2;
  logic clk = 0;
  logic reset = 1, ena = 0, mode = 0, step = 0, seed_load = 0, out_ready = 0;
  logic [15:0] seed_data = 0;
  logic [7:0] seed_ctrl = 0;
  logic out_valid, lockup, overrun;
  logic [7:0] out_data;
  int n_chk = 0, n_fail = 0;
  int m_cd, m_cc;
  logic [15:0] m_data;
  logic [7:0] m_ctrl, m_out;
  logic m_valid, m_lock, m_ovr;

  prng_mux_engine #(.DIV_DATA(24'd4), .DIV_CTRL(24'd2)) dut (
    .clk(clk), .reset(reset), .ena(ena), .mode(mode), .step(step),
    .seed_load(seed_load), .seed_data(seed_data), .seed_ctrl(seed_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .lockup(lockup), .overrun(overrun));

  always #5 clk = ~clk;

  function automatic int nxt(input int v, input int taps, input int w);
    int n;
    n = ((v << 1) | ($countones(v & taps) % 2 == 0 ? 1 : 0)) & ((1 << w) - 1);
    return n;
  endfunction

  task automatic cyc();
    logic run, td, tc, st, samp;
    int n;
    if (reset) begin
      m_cd = 0; m_cc = 0; m_data = 0; m_ctrl = 0;
      m_out = 0; m_valid = 0; m_lock = 0; m_ovr = 0;
    end else if (seed_load) begin
      m_data = seed_data; m_ctrl = seed_ctrl; m_cd = 0; m_cc = 0; m_lock = 0;
      if (m_valid && out_ready) m_valid = 0;
    end else begin
      run = ena && !mode;
      td = run && m_cd == DD - 1;
      tc = run && m_cc == DC - 1;
      st = ena && mode && step;
      if (run) begin m_cd = (m_cd + 1) % DD; m_cc = (m_cc + 1) % DC; end
      if (td || st) begin
        n = nxt(int'(m_data), 'hD008, 16);
        if (n == 'hFFFF) begin n = 0; m_lock = 1; end
        m_data = n[15:0];
      end
      if (tc || st) begin
        n = nxt(int'(m_ctrl), 'hB8, 8);
        if (n == 'hFF) begin n = 0; m_lock = 1; end
        m_ctrl = n[7:0];
      end
      samp = td || st;
      if (samp) begin
        if (!m_valid || out_ready) begin
          for (int i = 0; i < 8; i++) m_out[i] = m_ctrl[i] ? m_data[2*i+1] : m_data[2*i];
          m_valid = 1;
        end else m_ovr = 1;
      end else if (m_valid && out_ready) m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; seed_load = 0; step = 0; ena = 0; mode = 0; out_ready = 0;
    cyc();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; ena = 1; seed_load = 1; seed_data = 16'hABCD; out_ready = 1;
    cyc();
    n_chk++;
    if ({out_valid, out_data, lockup, overrun, dut.data_q, dut.ctrl_q} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset: got v=%b d=%h l=%b o=%b data=%h ctrl=%h exp all 0", out_valid, out_data, lockup, overrun, dut.data_q, dut.ctrl_q);
    end
    do_reset();
  endtask

  task automatic test_step();
    do_reset();
    mode = 1; ena = 1; step = 1;
    cyc();
    step = 0;
    n_chk++;
    if ({dut.data_q, dut.ctrl_q, out_data, out_valid} !== {16'h0001, 8'h01, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL step1: got data=%h ctrl=%h out=%h v=%b exp 0001 01 00 1", dut.data_q, dut.ctrl_q, out_data, out_valid);
    end
    out_ready = 1; step = 1;
    cyc();
    step = 0;
    n_chk++;
    if ({dut.data_q, dut.ctrl_q, out_data, out_valid} !== {16'h0003, 8'h03, 8'h01, 1'b1}) begin
      n_fail++;
      $display("FAIL step2: got data=%h ctrl=%h out=%h v=%b exp 0003 03 01 1", dut.data_q, dut.ctrl_q, out_data, out_valid);
    end
  endtask

  task automatic test_free_run();
    do_reset();
    mode = 0; ena = 1; out_ready = 0;
    for (int c = 0; c <= 8; c++) begin
      if (c == 2) begin
        n_chk++;
        if (dut.ctrl_q !== 8'h01 || dut.data_q !== 16'h0) begin n_fail++; $display("FAIL free_c2: got ctrl=%h data=%h exp 01 0000", dut.ctrl_q, dut.data_q); end
      end
      if (c == 3) begin
        n_chk++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL free_c3_valid: got %b exp 0", out_valid); end
      end
      if (c == 4) begin
        n_chk++;
        if ({out_valid, out_data, dut.ctrl_q, dut.data_q} !== {1'b1, 8'h00, 8'h03, 16'h0001}) begin
          n_fail++; $display("FAIL free_c4: got v=%b out=%h ctrl=%h data=%h exp 1 00 03 0001", out_valid, out_data, dut.ctrl_q, dut.data_q);
        end
      end
      if (c == 7) begin
        n_chk++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL free_c7_ovr: got %b exp 0", overrun); end
      end
      if (c == 8) begin
        n_chk++;
        if ({overrun, out_valid, out_data} !== {1'b1, 1'b1, 8'h00}) begin
          n_fail++; $display("FAIL free_c8_overrun: got ovr=%b v=%b out=%h exp 1 1 00", overrun, out_valid, out_data);
        end
      end
      cyc();
    end
  endtask

  task automatic test_lockup();
    do_reset();
    seed_load = 1; seed_data = 16'hFFFF; seed_ctrl = 8'h00;
    cyc();
    seed_load = 0;
    n_chk++;
    if (dut.data_q !== 16'hFFFF || lockup !== 1'b0) begin n_fail++; $display("FAIL lock_seed: got data=%h lock=%b exp ffff 0", dut.data_q, lockup); end
    mode = 1; ena = 1; step = 1;
    cyc();
    step = 0;
    n_chk++;
    if (dut.data_q !== 16'h0000 || lockup !== 1'b1) begin n_fail++; $display("FAIL lock_step: got data=%h lock=%b exp 0000 1", dut.data_q, lockup); end
    seed_load = 1; seed_data = 16'h00A5;
    cyc();
    seed_load = 0;
    n_chk++;
    if (lockup !== 1'b0) begin n_fail++; $display("FAIL lock_clear: got %b exp 0", lockup); end
  endtask

  task automatic test_streaming();
    int xfers = 0;
    do_reset();
    mode = 0; ena = 1; out_ready = 1;
    for (int c = 0; c <= 40; c++) begin
      n_chk++;
      if (out_valid !== (c >= 4 && c % 4 == 0)) begin n_fail++; $display("FAIL stream_valid c=%0d: got %b exp %b", c, out_valid, c >= 4 && c % 4 == 0); end
      if (out_valid) xfers++;
      cyc();
    end
    n_chk++;
    if (xfers != 10 || overrun !== 1'b0) begin n_fail++; $display("FAIL stream_count: got xfers=%0d ovr=%b exp 10 0", xfers, overrun); end
  endtask

  task automatic test_back_to_back_seed();
    do_reset();
    mode = 1; ena = 1; step = 1; out_ready = 0;
    cyc();
    seed_load = 1; seed_data = 16'h1234; seed_ctrl = 8'($urandom);
    cyc();
    seed_load = 0; step = 0;
    n_chk++;
    if (dut.data_q !== 16'h1234 || dut.ctrl_q !== seed_ctrl || out_valid !== m_valid || m_valid !== 1'b1) begin
      n_fail++; $display("FAIL seed_vs_step: got data=%h ctrl=%h v=%b exp 1234 %h %b", dut.data_q, dut.ctrl_q, out_valid, seed_ctrl, m_valid);
    end
  endtask

  task automatic test_reset_ena();
    int k;
    do_reset();
    mode = 0; ena = 1; out_ready = 0;
    for (int c = 0; c < 9; c++) cyc();
    reset = 1;
    cyc();
    reset = 0;
    n_chk++;
    if ({out_valid, out_data, lockup, overrun} !== 11'd0) begin n_fail++; $display("FAIL midrun_reset: got v=%b d=%h l=%b o=%b exp 0", out_valid, out_data, lockup, overrun); end
    k = 0;
    while (!out_valid && k < 20) begin cyc(); k++; end
    n_chk++;
    if (!out_valid) begin n_fail++; $display("FAIL ena_wait: got valid=0 exp 1 within 20 cycles"); end
    ena = 0;
    for (int c = 0; c < 20; c++) cyc();
    n_chk++;
    if (dut.data_q !== m_data || dut.ctrl_q !== m_ctrl || out_valid !== 1'b1 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL ena_hold: got data=%h ctrl=%h v=%b o=%b exp %h %h 1 0", dut.data_q, dut.ctrl_q, out_valid, overrun, m_data, m_ctrl);
    end
    out_ready = 1;
    cyc();
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ena_drain: got %b exp 0", out_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(63) == 0);
      seed_load = ($urandom_range(15) == 0);
      seed_data = 16'($urandom);
      seed_ctrl = 8'($urandom);
      if ($urandom_range(31) == 0) mode = ~mode;
      ena = ($urandom_range(9) != 0);
      step = $urandom_range(1);
      out_ready = $urandom_range(1);
      cyc();
      n_chk++;
      if ({out_valid, out_data, lockup, overrun, dut.data_q, dut.ctrl_q} !== {m_valid, m_out, m_lock, m_ovr, m_data, m_ctrl}) begin
        n_fail++;
        $display("FAIL random c=%0d: got v=%b d=%h l=%b o=%b data=%h ctrl=%h exp %b %h %b %b %h %h", c,
                 out_valid, out_data, lockup, overrun, dut.data_q, dut.ctrl_q, m_valid, m_out, m_lock, m_ovr, m_data, m_ctrl);
      end
    end
    reset = 0;
    seed_load = 0;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_step();
    test_free_run();
    test_lockup();
    test_streaming();
    test_back_to_back_seed();
    test_reset_ena();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prng_mux_engine.md
# prng_mux_engine

Parametrised pseudo-random byte generator. Two XNOR-feedback LFSRs, a wide data register and a half-width control register, advance on internal clock-enable ticks. Each control bit selects one of a pair of data bits, and the result is presented on a valid/ready output register. It replaces derived-clock dividers with single-clock tick enables and adds seeding, single-step mode, lockup recovery and overrun reporting; it sits between the tile I/O and the 7-segment decoders.

## Interface

Parameters:

- `DATA_W`, 16: data LFSR width; must be even, range 4..32. `CW = DATA_W/2` is the control LFSR width and the output width.
- `DATA_TAPS`, 16'hD008: `DATA_W`-bit tap mask, bits 15,14,12,3.
- `CTRL_TAPS`, 8'hB8: `CW`-bit tap mask, bits 7,5,4,3.
- `DIV_DATA`, 24'd10_000_000: clk cycles per data tick; ≥2.
- `DIV_CTRL`, 24'd2_500_000: clk cycles per control tick; ≥2.

Ports:

- `clk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `ena`, in, 1: run enable. When low, dividers hold, ticks and steps are ignored, and the handshake still operates.
- `mode`, in, 1: 0 = free-run on ticks; 1 = single-step.
- `step`, in, 1: in mode 1, each high cycle advances both LFSRs once.
- `seed_load`, in, 1: load seeds this cycle.
- `seed_data`, in, `DATA_W`: data LFSR seed.
- `seed_ctrl`, in, `CW`: control LFSR seed.
- `out_valid`, out, 1: `out_data` holds an untransferred sample.
- `out_ready`, in, 1: consumer accepts.
- `out_data`, out, `CW`: sample.
- `lockup`, out, 1: sticky; an LFSR hit its all-ones lock state.
- `overrun`, out, 1: sticky; a sample was dropped.

## Operation

- **Reset:** both LFSRs = 0, both dividers = 0, `out_valid`, `out_data`, `lockup` and `overrun` all = 0. Reset overrides every other input.
- **Dividers:** each counts 0..DIV-1 while `ena` = 1 and `mode` = 0, then wraps to 0. Its tick is high in the cycle where count == DIV-1. With `mode` = 1 or `ena` = 0, counts hold.
- **Advance:** `lfsr <= {lfsr[W-2:0], fb}` where `fb = ~^(lfsr & TAPS)`.
  - The data LFSR advances on a data tick. The control LFSR advances on a control tick. Both advance on a step (`mode` = 1, `ena` = 1, `step` = 1).
  - A data tick and a control tick in the same cycle advance both.
- **Lockup:** if an LFSR's next value would be all-ones, load 0 instead and set `lockup`. A seed of all-ones is loaded as given; lockup is caught on its next advance.
- **Seed:** `seed_load` = 1 has priority over advance.
  - Loads both LFSRs, clears both dividers to 0, clears `lockup`.
  - No sample is produced; the output register and `overrun` are untouched.
  - Seeding works regardless of `ena`.
- **Scramble:** `s[i] = ctrl[i] ? data[2i+1] : data[2i]` for i in 0..CW-1.
  - It is evaluated on the post-edge LFSR values, including a simultaneous control advance.
- **Sample event:** a cycle in which the data LFSR advances. A control-only advance produces no sample.
- **Output register:**
  - Sample while `out_valid` = 0, or while `out_valid` = 1 and `out_ready` = 1: load `s`, set `out_valid` = 1.
  - Sample while `out_valid` = 1 and `out_ready` = 0: sample is dropped, `out_data` is unchanged, `overrun` is set.
  - No sample, with `out_valid` and `out_ready` both high: `out_valid` clears and `out_data` holds its value.
- `lockup` and `overrun` clear only on reset; `lockup` also clears on seed.

## Timing

- Tick or step in cycle N: LFSRs update at the end-of-N edge. `out_valid` and `out_data` are visible in cycle N+1, a 1-cycle latency.
- Transfer occurs on any edge with `out_valid` and `out_ready` both high. `out_valid` never drops without a transfer except on reset.
- First data tick after reset or seed occurs in cycle DIV_DATA-1, counted from the first non-reset cycle. The first control tick is in cycle DIV_CTRL-1.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

Defaults, except where the divider values are overridden as stated.

1. **Single-step from zero.** Reset, then `mode` = 1, `ena` = 1, step twice.
   - After step 1: data = 0x0001, ctrl = 0x01, out_data = 0x00.
   - After step 2: data = 0x0003, ctrl = 0x03, out_data = 0x01.
   - `out_valid` is high one cycle after each step.
2. **Free-run and overrun.** DIV_DATA = 4, DIV_CTRL = 2, `out_ready` = 0.
   - Control advances at the ends of cycles 1 and 3; data advances at the end of cycle 3.
   - `out_valid` = 1 in cycle 4 with out_data = 0x00.
   - At the data tick in cycle 7, `overrun` = 1 and out_data stays 0x00.
3. **Lockup.** Seed data = 0xFFFF, ctrl = 0x00, then step. Data becomes 0x0000 and `lockup` = 1. A further `seed_load` clears `lockup`.
4. **Streaming.** `out_ready` held 1 in free-run. Every data tick yields one transfer, `out_valid` drops the cycle after each transfer, and `overrun` stays 0.
5. **Seed versus step.** `seed_load` and `step` in the same cycle with seed data = 0x1234. The LFSR equals 0x1234 with no advance, and `out_valid` is unchanged.
6. **Mid-run reset and enable.** Pulse `reset` mid-stream: all outputs are 0 in the next cycle. Hold `ena` = 0 for 20 cycles: no ticks occur, but a pending sample still drains via `out_ready`.
